tff_sync: RTL and testbench

TFF_SYNC -- requirements
Module: tff_sync

---
 rtl/tff_sync.sv | 35 +++
 tb/tb_tff_sync.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tff_sync.sv
`default_nettype none
// ============================================================================
// Module   : tff_sync
// Brief    : WIDTH independent toggle flip-flops, synchronous active-low reset
// Revision : 1.0
// ============================================================================
module tff_sync #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  localparam logic [WIDTH-1:0] c_reset_value = RESET_VALUE;

  logic [WIDTH-1:0] r_q;

  // Reset wins over any toggle request sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= c_reset_value;
    end else begin
      r_q <= r_q ^ T;
    end
  end

  assign Q   = r_q;
  assign Q_n = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_tff_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_sync
// Brief    : directed self-checking bench for tff_sync (WIDTH=1 and WIDTH=4)
// Revision : 1.0
// ============================================================================
module tb_tff_sync;

  logic       clk;
  logic       r1;
  logic [0:0] t1;
  logic [0:0] q1;
  logic [0:0] qn1;
  logic       r4;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qn4;

  int n_total;
  int n_bad;

  tff_sync #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .reset(r1),
    .T    (t1),
    .Q    (q1),
    .Q_n  (qn1)
  );

  tff_sync #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut4 (
    .clk  (clk),
    .reset(r4),
    .T    (t4),
    .Q    (q4),
    .Q_n  (qn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    r1 = 1'b0; t1 = 1'b0;
    r4 = 1'b0; t4 = 4'b0000;

    // Reset edge
    edge_step();
    check("w1_rst_q",  {63'd0, q1},  64'd0);
    check("w1_rst_qn", {63'd0, qn1}, 64'd1);
    check("w4_rst_q",  {60'd0, q4},  64'hA);
    check("w4_rst_qn", {60'd0, qn4}, 64'h5);

    // Toggle train: 1,0,1,0 on WIDTH=1; per-bit toggle on WIDTH=4
    r1 = 1'b1; t1 = 1'b1;
    r4 = 1'b1; t4 = 4'b0011;
    edge_step();
    check("w1_tog0", {63'd0, q1}, 64'd1);
    check("w4_q_0011",  {60'd0, q4},  64'h9);
    check("w4_qn_0011", {60'd0, qn4}, 64'h6);
    t4 = 4'b1111;
    edge_step();
    check("w1_tog1", {63'd0, q1}, 64'd0);
    check("w4_q_1111", {60'd0, q4}, 64'h6);
    t4 = 4'b0000;
    edge_step();
    check("w1_tog2", {63'd0, q1}, 64'd1);
    check("w4_hold", {60'd0, q4}, 64'h6);
    edge_step();
    check("w1_tog3", {63'd0, q1}, 64'd0);

    // Get to Q=1 then hold with T=0
    edge_step();
    check("w1_to1", {63'd0, q1}, 64'd1);
    t1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("w1_hold", {63'd0, q1}, 64'd1);
    end

    // Reset and toggle together: reset wins, then toggling resumes
    r1 = 1'b0; t1 = 1'b1;
    edge_step();
    check("w1_rst_wins",    {63'd0, q1},  64'd0);
    check("w1_rst_wins_qn", {63'd0, qn1}, 64'd1);
    r1 = 1'b1;
    edge_step();
    check("w1_resume", {63'd0, q1}, 64'd1);

    // Reset held for several edges
    r1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("w1_rst_hold", {63'd0, q1}, 64'd0);
    end

    // Deassertion alone does not toggle
    r1 = 1'b1; t1 = 1'b0;
    edge_step();
    check("w1_deassert", {63'd0, q1}, 64'd0);
    t1 = 1'b1;
    edge_step();
    check("w1_first_tog", {63'd0, q1}, 64'd1);

    // Pulses between edges must not affect Q
    t1 = 1'b0;
    #2;
    t1 = 1'b1; r1 = 1'b0;
    #2;
    t1 = 1'b0; r1 = 1'b1;
    check("w1_mid_pulse", {63'd0, q1}, 64'd1);
    edge_step();
    check("w1_after_pulse",    {63'd0, q1},  64'd1);
    check("w1_after_pulse_qn", {63'd0, qn1}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
